alu_ctrl_seq: RTL

//  Registered, parametrised ALU controller for the MIPS datapath. Decodes ALUOp/funct into the ALU

---
 rtl/alu_ctrl_seq_pkg.sv | 82 ++++++++
 rtl/alu_ctrl_seq_decode.sv | 49 ++++
 rtl/alu_ctrl_seq.sv | 120 ++++++++++++
 3 files changed

// File: rtl/alu_ctrl_seq_pkg.sv
// Shared types and encodings for the registered ALU controller.
// ALUOp, funct and ALU control codes plus the sequencer state.
package alu_ctrl_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_BEQ   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_BNE   = 3'b011;
  localparam logic [2:0] OP_ADDI  = 3'b100;
  localparam logic [2:0] OP_LUI   = 3'b101;
  localparam logic [2:0] OP_ORI   = 3'b110;

  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_SRAV  = 6'b000111;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_NE   = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLTU = 4'b0111;
  localparam logic [3:0] C_SLT  = 4'b1000;
  localparam logic [3:0] C_SRA  = 4'b1001;
  localparam logic [3:0] C_SRAV = 4'b1010;
  localparam logic [3:0] C_LUI  = 4'b1011;
  localparam logic [3:0] C_MDU  = 4'b1100;
  localparam logic [3:0] C_MFHI = 4'b1101;
  localparam logic [3:0] C_MFLO = 4'b1110;
  localparam logic [3:0] C_ILL  = 4'b1111;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       is_mdu;
    logic [1:0] mdu_op;
    logic       illegal;
  } dec_t;

  function automatic dec_t dec_ok(input logic [3:0] ctrl);
    dec_t d;
    d.ctrl    = ctrl;
    d.is_mdu  = 1'b0;
    d.mdu_op  = 2'b00;
    d.illegal = 1'b0;
    return d;
  endfunction

  function automatic dec_t dec_bad();
    dec_t d;
    d.ctrl    = C_ILL;
    d.is_mdu  = 1'b0;
    d.mdu_op  = 2'b00;
    d.illegal = 1'b1;
    return d;
  endfunction

  function automatic dec_t dec_mdu(input logic [1:0] op);
    dec_t d;
    d.ctrl    = C_MDU;
    d.is_mdu  = 1'b1;
    d.mdu_op  = op;
    d.illegal = 1'b0;
    return d;
  endfunction

endpackage

// File: rtl/alu_ctrl_seq_decode.sv
// Combinational (aluop, funct) -> ALU control table.
// ALUOp codes take priority; funct is consulted only for R-type.
module alu_ctrl_seq_decode
  import alu_ctrl_seq_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic [ALUOP_W-1:0] aluop,
  input  logic [5:0]         funct,
  output dec_t               dec
);

  dec_t rdec;

  always_comb begin
    rdec = dec_bad();
    unique case (funct)
      F_ADDU:  rdec = dec_ok(C_ADD);
      F_SUBU:  rdec = dec_ok(C_SUB);
      F_AND:   rdec = dec_ok(C_AND);
      F_OR:    rdec = dec_ok(C_OR);
      F_SLT:   rdec = dec_ok(C_SLT);
      F_SLTU:  rdec = dec_ok(C_SLTU);
      F_SRA:   rdec = dec_ok(C_SRA);
      F_SRAV:  rdec = dec_ok(C_SRAV);
      F_MFHI:  rdec = dec_ok(C_MFHI);
      F_MFLO:  rdec = dec_ok(C_MFLO);
      F_MULT,
      F_MULTU,
      F_DIV,
      F_DIVU:  rdec = dec_mdu(funct[1:0]);
      default: rdec = dec_bad();
    endcase
  end

  always_comb begin
    dec = dec_bad();
    unique case (1'b1)
      aluop == ALUOP_W'(OP_ADDI):  dec = dec_ok(C_ADD);
      aluop == ALUOP_W'(OP_BEQ):   dec = dec_ok(C_SUB);
      aluop == ALUOP_W'(OP_LUI):   dec = dec_ok(C_LUI);
      aluop == ALUOP_W'(OP_ORI):   dec = dec_ok(C_OR);
      aluop == ALUOP_W'(OP_BNE):   dec = dec_ok(C_NE);
      aluop == ALUOP_W'(OP_RTYPE): dec = rdec;
      default:                     dec = dec_bad();
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU controller with multi-cycle MDU sequencing.
// One-cycle decode latency; MDU ops stall the pipe while BUSY.
module alu_ctrl_seq
  import alu_ctrl_seq_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int ALUOP_W    = 3,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  input  logic [ALUOP_W-1:0] aluop_i,
  input  logic [5:0]         funct_i,
  input  logic               flush_i,
  output logic               ready_o,
  output logic               valid_o,
  output logic [CTRL_W-1:0]  aluctrl_o,
  output logic               illegal_o,
  output logic               mdu_start_o,
  output logic [1:0]         mdu_op_o,
  output logic               hilo_we_o,
  output logic               stall_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES + 1);

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_n;
  logic              valid_n;
  logic [CTRL_W-1:0] ctrl_n;
  logic              ill_n;
  logic              start_n;
  logic [1:0]        op_n;
  logic              hilo_n;
  logic              accept;
  dec_t              dec;

  alu_ctrl_seq_decode #(
    .ALUOP_W (ALUOP_W)
  ) u_decode (
    .aluop (aluop_i),
    .funct (funct_i),
    .dec   (dec)
  );

  assign ready_o = (state == IDLE);
  assign stall_o = (state == BUSY);
  assign accept  = valid_i && ready_o && !flush_i;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    valid_n = 1'b0;
    ctrl_n  = aluctrl_o;
    ill_n   = 1'b0;
    start_n = 1'b0;
    op_n    = mdu_op_o;
    hilo_n  = 1'b0;
    if (flush_i) begin
      // DONE outputs are already visible; flush only redirects state
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && dec.is_mdu) begin
            state_n = BUSY;
            start_n = 1'b1;
            op_n    = dec.mdu_op;
            cnt_n   = dec.mdu_op[1] ? CNT_W'(DIV_CYCLES - 1)
                                    : CNT_W'(MUL_CYCLES - 1);
          end else if (accept) begin
            valid_n = 1'b1;
            ctrl_n  = CTRL_W'(dec.ctrl);
            ill_n   = dec.illegal;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            state_n = DONE;
            valid_n = 1'b1;
            ctrl_n  = CTRL_W'(C_MDU);
            hilo_n  = 1'b1;
          end else begin
            cnt_n = cnt - CNT_W'(1);
          end
        end
        DONE:    state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      valid_o     <= 1'b0;
      aluctrl_o   <= CTRL_W'(C_ILL);
      illegal_o   <= 1'b0;
      mdu_start_o <= 1'b0;
      mdu_op_o    <= 2'b00;
      hilo_we_o   <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      valid_o     <= valid_n;
      aluctrl_o   <= ctrl_n;
      illegal_o   <= ill_n;
      mdu_start_o <= start_n;
      mdu_op_o    <= op_n;
      hilo_we_o   <= hilo_n;
    end
  end

endmodule
